// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the control unit. The datapath and benches
// import the state enumeration from here.
package cu_pkg;

    typedef enum logic [2:0] {
        RST_SP    = 3'd0,
        RST_PC    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        WRITEBACK = 3'd5
    } cu_state_e;

endpackage : cu_pkg

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer. It steps
// RST_SP -> RST_PC -> FETCH -> DECODE -> EXECUTE -> WRITEBACK and produces the
// datapath enables and register load strobes.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   update_flags decoded instruction updates APSR flags
//   write_rd     decoded instruction writes Rd
//   ig_ex        decoded instruction is skipped
//   br_en        branch taken
//   cu_wr_mem    data-memory write strobe
//   branch       branch in progress
//   new_pc_en    PC source: 1 = vector/branch target, 0 = PC+2
//   cu_decode    datapath decode enable
//   cu_execute   datapath execute enable
//   ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ild_primask
//                register load strobes
module control_unit
    import cu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic update_flags,
    input  logic write_rd,
    input  logic ig_ex,
    input  logic br_en,
    output logic cu_wr_mem,
    output logic branch,
    output logic new_pc_en,
    output logic cu_decode,
    output logic cu_execute,
    output logic ld_sp,
    output logic ld_lr,
    output logic ld_pc,
    output logic ld_rd,
    output logic ld_apsr,
    output logic ld_ipsr,
    output logic ild_primask
);

    cu_state_e state_q;
    cu_state_e state_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_SP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RST_SP:    state_d = RST_PC;
            RST_PC:    state_d = FETCH;
            FETCH:     state_d = DECODE;
            DECODE:    state_d = ig_ex ? FETCH : EXECUTE;
            EXECUTE: begin
                // A taken branch wins over a pending Rd write.
                if (br_en) begin
                    state_d = FETCH;
                end else if (write_rd) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FETCH;
                end
            end
            WRITEBACK: state_d = FETCH;
            default:   state_d = RST_SP;
        endcase
    end

    // Output decode. All strobes are gated by rst so that nothing fires while
    // reset is held, even though the state register already sits in RST_SP.
    always_comb begin
        cu_wr_mem   = 1'b0;
        branch      = 1'b0;
        new_pc_en   = 1'b0;
        cu_decode   = 1'b0;
        cu_execute  = 1'b0;
        ld_sp       = 1'b0;
        ld_lr       = 1'b0;
        ld_pc       = 1'b0;
        ld_rd       = 1'b0;
        ld_apsr     = 1'b0;
        ld_ipsr     = 1'b0;
        ild_primask = 1'b0;
        if (rst) begin
            case (state_q)
                RST_SP: begin
                    ld_sp       = 1'b1;
                    ld_lr       = 1'b1;
                    ld_ipsr     = 1'b1;
                    ild_primask = 1'b1;
                end
                RST_PC: begin
                    ld_pc     = 1'b1;
                    new_pc_en = 1'b1;
                end
                FETCH: begin
                    ld_pc = 1'b1;
                end
                DECODE: begin
                    cu_decode = 1'b1;
                end
                EXECUTE: begin
                    cu_execute = 1'b1;
                    ld_apsr    = update_flags;
                    if (br_en) begin
                        branch    = 1'b1;
                        ld_pc     = 1'b1;
                        new_pc_en = 1'b1;
                    end else if (!write_rd && !update_flags) begin
                        // Neither Rd nor flags written: the instruction is a store.
                        cu_wr_mem = 1'b1;
                    end
                end
                WRITEBACK: begin
                    ld_rd = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule : control_unit

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit. Outputs are packed into a
// 12-bit vector {cu_wr_mem, branch, new_pc_en, cu_decode, cu_execute, ld_sp,
// ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ild_primask} and compared against
// hand-built expected vectors during the low phase of the clock.
module tb_control_unit;

    logic clk;
    logic rst;
    logic update_flags;
    logic write_rd;
    logic ig_ex;
    logic br_en;
    logic cu_wr_mem;
    logic branch;
    logic new_pc_en;
    logic cu_decode;
    logic cu_execute;
    logic ld_sp;
    logic ld_lr;
    logic ld_pc;
    logic ld_rd;
    logic ld_apsr;
    logic ld_ipsr;
    logic ild_primask;

    localparam logic [11:0] WR   = 12'h800;
    localparam logic [11:0] BR   = 12'h400;
    localparam logic [11:0] NP   = 12'h200;
    localparam logic [11:0] DEC  = 12'h100;
    localparam logic [11:0] EXE  = 12'h080;
    localparam logic [11:0] SP   = 12'h040;
    localparam logic [11:0] LR   = 12'h020;
    localparam logic [11:0] PC   = 12'h010;
    localparam logic [11:0] RD   = 12'h008;
    localparam logic [11:0] APSR = 12'h004;
    localparam logic [11:0] IPSR = 12'h002;
    localparam logic [11:0] PM   = 12'h001;

    localparam logic [11:0] E_NONE  = 12'h000;
    localparam logic [11:0] E_RSTSP = SP | LR | IPSR | PM;
    localparam logic [11:0] E_RSTPC = PC | NP;
    localparam logic [11:0] E_FETCH = PC;
    localparam logic [11:0] E_DEC   = DEC;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [11:0] outs;
    assign outs = {cu_wr_mem, branch, new_pc_en, cu_decode, cu_execute, ld_sp,
                   ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ild_primask};

    control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .update_flags (update_flags),
        .write_rd     (write_rd),
        .ig_ex        (ig_ex),
        .br_en        (br_en),
        .cu_wr_mem    (cu_wr_mem),
        .branch       (branch),
        .new_pc_en    (new_pc_en),
        .cu_decode    (cu_decode),
        .cu_execute   (cu_execute),
        .ld_sp        (ld_sp),
        .ld_lr        (ld_lr),
        .ld_pc        (ld_pc),
        .ld_rd        (ld_rd),
        .ld_apsr      (ld_apsr),
        .ld_ipsr      (ld_ipsr),
        .ild_primask  (ild_primask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] expected);
        n_cmp++;
        assert (outs === expected)
        else begin
            n_bad++;
            $error("FAIL %s: observed %03h expected %03h", tag, outs, expected);
        end
    endtask

    // Move to the next low phase, apply inputs, let them settle, then compare.
    task automatic step(input string tag, input logic uf, input logic wr,
                        input logic ig, input logic br, input logic [11:0] expected);
        @(negedge clk);
        update_flags = uf;
        write_rd     = wr;
        ig_ex        = ig;
        br_en        = br;
        #1;
        check(tag, expected);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b0;
        update_flags = 1'b0;
        write_rd     = 1'b0;
        ig_ex        = 1'b0;
        br_en        = 1'b0;

        // Held in reset across edges, with inputs toggling: nothing fires.
        step("reset_quiet",   1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        step("reset_inputs",  1'b1, 1'b1, 1'b1, 1'b1, E_NONE);

        // Release mid low-phase: RST_SP strobes before the first edge.
        update_flags = 1'b0;
        write_rd     = 1'b0;
        ig_ex        = 1'b0;
        br_en        = 1'b0;
        rst          = 1'b1;
        #1;
        check("rst_sp", E_RSTSP);
        step("rst_pc",        1'b1, 1'b1, 1'b1, 1'b1, E_RSTPC);
        step("fetch0",        1'b1, 1'b1, 1'b0, 1'b1, E_FETCH);
        // Skipped instruction: 2-cycle latency, no execute.
        step("decode_skip",   1'b0, 1'b0, 1'b1, 1'b0, E_DEC);
        step("fetch_skip",    1'b0, 1'b0, 1'b0, 1'b0, E_FETCH);

        // Rd + flags: 4-cycle latency.
        step("decode_rd",     1'b0, 1'b0, 1'b0, 1'b0, E_DEC);
        step("exec_rd_flags", 1'b1, 1'b1, 1'b0, 1'b0, EXE | APSR);
        step("writeback",     1'b1, 1'b1, 1'b1, 1'b1, RD);
        step("fetch_after_wb",1'b0, 1'b0, 1'b0, 1'b0, E_FETCH);

        // Branch with write_rd: branch wins, no writeback.
        step("decode_br",     1'b0, 1'b0, 1'b0, 1'b0, E_DEC);
        step("exec_branch",   1'b0, 1'b1, 1'b0, 1'b1, EXE | BR | PC | NP);
        step("fetch_after_br",1'b0, 1'b0, 1'b0, 1'b0, E_FETCH);

        // Branch with flags: ld_apsr follows update_flags, still no store.
        step("decode_brf",    1'b0, 1'b0, 1'b0, 1'b0, E_DEC);
        step("exec_br_flags", 1'b1, 1'b0, 1'b0, 1'b1, EXE | APSR | BR | PC | NP);
        step("fetch_after_bf",1'b0, 1'b0, 1'b0, 1'b0, E_FETCH);

        // Store: single-cycle write strobe.
        step("decode_st",     1'b0, 1'b0, 1'b0, 1'b0, E_DEC);
        step("exec_store",    1'b0, 1'b0, 1'b0, 1'b0, EXE | WR);
        step("fetch_after_st",1'b0, 1'b0, 1'b0, 1'b0, E_FETCH);

        // Flag-only: 3-cycle latency.
        step("decode_fl",     1'b0, 1'b0, 1'b0, 1'b0, E_DEC);
        step("exec_flags",    1'b1, 1'b0, 1'b0, 1'b0, EXE | APSR);
        step("fetch_after_fl",1'b0, 1'b0, 1'b0, 1'b0, E_FETCH);

        // Async reset mid-EXECUTE of an Rd instruction.
        step("decode_abort",  1'b0, 1'b0, 1'b0, 1'b0, E_DEC);
        step("exec_abort",    1'b0, 1'b1, 1'b0, 1'b0, EXE);
        rst = 1'b0;
        #1;
        check("abort_zero", E_NONE);
        step("abort_held",    1'b0, 1'b1, 1'b0, 1'b0, E_NONE);
        write_rd = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_sp_again", E_RSTSP);
        step("rst_pc_again",  1'b0, 1'b0, 1'b0, 1'b0, E_RSTPC);
        step("fetch_again",   1'b0, 1'b0, 1'b0, 1'b0, E_FETCH);
        step("decode_again",  1'b0, 1'b0, 1'b0, 1'b0, E_DEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_control_unit

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 update_flags  input  1  decoded instruction updates APSR flags.
REQ-005 write_rd  input  1  decoded instruction writes a destination register.
REQ-006 ig_ex  input  1  decoded instruction is skipped (NOP or condition failed).
REQ-007 br_en  input  1  branch taken; the datapath supplies the target.
REQ-008 cu_wr_mem  output  1  data-memory write strobe.
REQ-009 branch  output  1  branch in progress.
REQ-010 new_pc_en  output  1  PC source select: 1 = vector/branch target, 0 = PC+2.
REQ-011 cu_decode  output  1  datapath decode enable.
REQ-012 cu_execute  output  1  datapath execute enable.
REQ-013 ld_sp, ld_lr, ld_pc, ld_rd, ld_apsr, ld_ipsr, ild_primask  output  1 each  register load strobes (SP, LR, PC, Rd, APSR, IPSR, PRIMASK).
REQ-014 The block SHALL have no parameters.

Function
REQ-015 The block SHALL be an FSM with states RST_SP, RST_PC, FETCH, DECODE, EXECUTE, WRITEBACK.
REQ-016 Outputs SHALL be combinational from the current state and current inputs; any output not listed for a state SHALL be 0.
REQ-017 In RST_SP, ld_sp, ld_lr, ld_ipsr and ild_primask SHALL be 1, and the next state SHALL be RST_PC.
REQ-018 In RST_PC, ld_pc and new_pc_en SHALL be 1, and the next state SHALL be FETCH.
REQ-019 In FETCH, ld_pc SHALL be 1 with new_pc_en 0 (PC+2), and the next state SHALL be DECODE.
REQ-020 In DECODE, cu_decode SHALL be 1; the next state SHALL be FETCH if ig_ex is 1, otherwise EXECUTE.
REQ-021 In EXECUTE, cu_execute SHALL be 1 and ld_apsr SHALL equal update_flags.
REQ-022 In EXECUTE with br_en 1, the block SHALL assert branch, ld_pc and new_pc_en, and go to FETCH; br_en has priority over all other inputs.
REQ-023 In EXECUTE with br_en 0 and write_rd 1, the next state SHALL be WRITEBACK.
REQ-024 In EXECUTE with br_en, write_rd and update_flags all 0, the instruction is a store: cu_wr_mem SHALL be 1 for exactly that cycle, and the next state SHALL be FETCH.
REQ-025 In EXECUTE with br_en 0, write_rd 0 and update_flags 1, the next state SHALL be FETCH.
REQ-026 In WRITEBACK, ld_rd SHALL be 1 and the next state SHALL be FETCH.
REQ-027 Instruction latency SHALL be:
- 2 cycles for a skipped instruction;
- 3 cycles for branch, store or flag-only instructions;
- 4 cycles for instructions that write Rd.
REQ-028 Inputs SHALL be ignored in every state except DECODE (ig_ex) and EXECUTE (update_flags, write_rd, br_en).
REQ-029 cu_wr_mem and branch SHALL never be 1 in the same cycle.

Reset
REQ-030 While rst is 0, the state SHALL be forced to RST_SP immediately, independent of clk.
REQ-031 While rst is 0, all outputs SHALL be 0.
REQ-032 On the first rising clk edge after rst returns to 1, the FSM SHALL leave RST_SP; RST_SP outputs SHALL be driven during the cycle between release and that edge.
REQ-033 Asserting reset in any state, including mid-EXECUTE, SHALL abort the instruction with no further strobes.

Structure
REQ-034 The state enumeration SHALL live in a shared package, cu_pkg, so the datapath and benches can reference it.
REQ-035 There SHALL be no sub-modules: the design is one state register, one next-state block and one output-decode block.

Verification
REQ-036 Reset release, then 3 clocks -> strobes in this order:
- cycle 0: ld_sp, ld_lr, ld_ipsr, ild_primask = 1;
- cycle 1: ld_pc = 1, new_pc_en = 1;
- cycle 2: ld_pc = 1, new_pc_en = 0;
- cycle 3: cu_decode = 1.
REQ-037 In DECODE, ig_ex = 1 -> next cycle is FETCH; cu_execute stays 0 throughout.
REQ-038 In EXECUTE, write_rd = 1 and update_flags = 1 -> cu_execute = 1 and ld_apsr = 1, then ld_rd = 1 on the next cycle, then FETCH.
REQ-039 In EXECUTE, br_en = 1 and write_rd = 1 -> branch, ld_pc and new_pc_en = 1; ld_rd is never asserted; next state is FETCH.
REQ-040 In EXECUTE, all inputs 0 -> cu_wr_mem = 1 for exactly one cycle, then FETCH.
REQ-041 rst = 0 asynchronously during EXECUTE -> all outputs 0 within the same cycle; after release, the RST_SP strobes repeat.
